// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every handshake/bus signal around the two-requester memory arbiter:
//   the IFU read port, the LSU read/write port and the shared memory slave port.
//   Signal names keep their direction suffix as seen from the arbiter
//   (_i = into the arbiter, _o = out of the arbiter).
//
//   Modports:
//     slave  - the arbiter's view (it serves the IFU/LSU request ports).
//     master - the surrounding environment's view (requesters + memory slave).
//
//   Parameters:
//     ADDR_WIDTH - request address width.
//     DATA_WIDTH - data width; byte strobes are DATA_WIDTH/8 wide.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // IFU request / response
  logic                  ifu_req_valid_i;
  logic                  ifu_req_ready_o;
  logic [ADDR_WIDTH-1:0] ifu_addr_i;
  logic                  ifu_resp_valid_o;
  logic                  ifu_resp_ready_i;
  logic [DATA_WIDTH-1:0] ifu_rdata_o;

  // LSU request / response
  logic                  lsu_req_valid_i;
  logic                  lsu_req_ready_o;
  logic [ADDR_WIDTH-1:0] lsu_addr_i;
  logic                  lsu_wen_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  logic [STRB_WIDTH-1:0] lsu_wstrb_i;
  logic                  lsu_resp_valid_o;
  logic                  lsu_resp_ready_i;
  logic [DATA_WIDTH-1:0] lsu_rdata_o;

  // Shared memory slave port
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_wen_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [STRB_WIDTH-1:0] mem_wstrb_o;
  logic                  mem_resp_valid_i;
  logic                  mem_resp_ready_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  ifu_req_valid_i, ifu_addr_i, ifu_resp_ready_i,
    output ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o,
    input  lsu_req_valid_i, lsu_addr_i, lsu_wen_i, lsu_wdata_i, lsu_wstrb_i,
           lsu_resp_ready_i,
    output lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o,
    output mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o,
           mem_resp_ready_o,
    input  mem_req_ready_i, mem_resp_valid_i, mem_rdata_i
  );

  modport master (
    output ifu_req_valid_i, ifu_addr_i, ifu_resp_ready_i,
    input  ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o,
    output lsu_req_valid_i, lsu_addr_i, lsu_wen_i, lsu_wdata_i, lsu_wstrb_i,
           lsu_resp_ready_i,
    input  lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o,
    input  mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o,
           mem_resp_ready_o,
    output mem_req_ready_i, mem_resp_valid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester, single-port memory arbiter. The IFU (read only) and the LSU
//   (read/write) compete for one memory slave port. One request is accepted at
//   a time, latched, presented to the slave with a valid/ready handshake, and
//   the slave's response is routed back to the requester that owns the
//   transaction. Exactly one transaction is outstanding at any time.
//
//   Ports:
//     clk_i    - clock, all state updates on the rising edge.
//     rst_n_i  - asynchronous, active-low reset. Abandons any in-flight
//                transaction; every output reads 0 while it is held.
//     bus      - mem_arbiter_if.slave: IFU port, LSU port, memory slave port.
//
//   Parameters:
//     ADDR_WIDTH - request address width (must match the interface).
//     DATA_WIDTH - data width (must match the interface).
//
//   Build option:
//     ARB_ROUND_ROBIN_EN - when defined, simultaneous IFU+LSU requests are
//       granted to whichever requester did not win last time. When undefined,
//       the LSU always wins a tie (fixed priority LSU > IFU).
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  mem_arbiter_if.slave  bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t                r_state;
  owner_t                r_owner;
  owner_t                r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_mem_req_valid;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic w_idle;
  logic w_resp;
  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_owner_ifu;
  logic w_owner_lsu;
  logic w_mem_resp_ready;
  logic w_resp_hs;

  assign w_idle = (r_state == ST_IDLE);
  assign w_resp = (r_state == ST_RESP);

  // Ownership of the response path is only meaningful in RESP; outside it both
  // requesters see an idle response port.
  assign w_owner_ifu = w_resp && (r_owner == OWN_IFU);
  assign w_owner_lsu = w_resp && (r_owner == OWN_LSU);

  // ---------------------------------------------------------------------------
  // Arbitration (IDLE only). The grant doubles as the requester's ready, so a
  // grant is always a completed request handshake. Gating with rst_n_i keeps
  // the ready outputs at 0 while reset is held even if a requester is valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    if (w_idle && rst_n_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.lsu_req_valid_i && bus.ifu_req_valid_i) begin
        // Tie: hand the port to whoever did not win the previous transaction.
        w_grant_lsu = (r_last_grant == OWN_IFU);
        w_grant_ifu = (r_last_grant == OWN_LSU);
      end else begin
        w_grant_lsu = bus.lsu_req_valid_i;
        w_grant_ifu = bus.ifu_req_valid_i;
      end
`else
      w_grant_lsu = bus.lsu_req_valid_i;
      w_grant_ifu = bus.ifu_req_valid_i && !bus.lsu_req_valid_i;
`endif
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // last_grant is still tracked in the fixed-priority build so both builds
  // carry identical state; nothing consumes it here.
  logic w_unused_last_grant;
  assign w_unused_last_grant = r_last_grant;
`endif

  // ---------------------------------------------------------------------------
  // Response routing: the owner's ready steers the slave handshake and the
  // slave's valid/data pass straight through to the owner only.
  // ---------------------------------------------------------------------------
  assign w_mem_resp_ready = (w_owner_ifu && bus.ifu_resp_ready_i) ||
                            (w_owner_lsu && bus.lsu_resp_ready_i);
  assign w_resp_hs        = bus.mem_resp_valid_i && w_mem_resp_ready;

  // ---------------------------------------------------------------------------
  // Control FSM with registered request-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state         <= ST_IDLE;
      r_owner         <= OWN_IFU;
      r_last_grant    <= OWN_IFU;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_mem_req_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_lsu) begin
            r_addr          <= bus.lsu_addr_i;
            r_wen           <= bus.lsu_wen_i;
            r_wdata         <= bus.lsu_wdata_i;
            r_wstrb         <= bus.lsu_wstrb_i;
            r_owner         <= OWN_LSU;
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_REQ;
          end else if (w_grant_ifu) begin
            // IFU traffic is always a plain read with no write payload.
            r_addr          <= bus.ifu_addr_i;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_owner         <= OWN_IFU;
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Latched fields stay put until the slave takes the request.
          if (bus.mem_req_ready_i) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (w_resp_hs) begin
            r_last_grant <= r_owner;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          r_mem_req_valid <= 1'b0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.ifu_req_ready_o  = w_grant_ifu;
  assign bus.lsu_req_ready_o  = w_grant_lsu;

  assign bus.mem_req_valid_o  = r_mem_req_valid;
  assign bus.mem_addr_o       = r_addr;
  assign bus.mem_wen_o        = r_wen;
  assign bus.mem_wdata_o      = r_wdata;
  assign bus.mem_wstrb_o      = r_wstrb;

  // Slave responses outside RESP are illegal; they are never acknowledged.
  assign bus.mem_resp_ready_o = w_mem_resp_ready;

  assign bus.ifu_resp_valid_o = w_owner_ifu && bus.mem_resp_valid_i;
  assign bus.ifu_rdata_o      = w_owner_ifu ? bus.mem_rdata_i : '0;

  // Write acks are forwarded as responses too; rdata is passed through as-is.
  assign bus.lsu_resp_valid_o = w_owner_lsu && bus.mem_resp_valid_i;
  assign bus.lsu_rdata_o      = w_owner_lsu ? bus.mem_rdata_i : '0;

`ifndef SYNTHESIS
  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (bus.mem_req_valid_o && !bus.mem_req_ready_i) |=>
      (bus.mem_req_valid_o && $stable(bus.mem_addr_o) && $stable(bus.mem_wen_o) &&
       $stable(bus.mem_wdata_o) && $stable(bus.mem_wstrb_o)));

  a_resp_onehot : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(bus.ifu_resp_valid_o && bus.lsu_resp_valid_o));

  a_ready_idle_only : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !w_idle |-> (!bus.ifu_req_ready_o && !bus.lsu_req_ready_o));

  a_grant_onehot : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(bus.ifu_req_ready_o && bus.lsu_req_ready_o));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  req_t          exp_req_q[$];
  logic [DW-1:0] exp_ifu_q[$];
  logic [DW-1:0] exp_lsu_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_t e;
    e.addr  = a;
    e.wen   = w;
    e.wdata = d;
    e.wstrb = s;
    exp_req_q.push_back(e);
  endtask

  // Monitor: pops expected items whenever a handshake is presented.
  initial begin
    req_t          e;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      #3;
      chk("mon_resp_onehot", 64'(bus.ifu_resp_valid_o && bus.lsu_resp_valid_o), 64'd0);
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mon_req_unexpected: addr 0x%0h, none expected", bus.mem_addr_o);
        end else begin
          e = exp_req_q.pop_front();
          chk("mon_req_addr",  64'(bus.mem_addr_o),  64'(e.addr));
          chk("mon_req_wen",   64'(bus.mem_wen_o),   64'(e.wen));
          chk("mon_req_wdata", 64'(bus.mem_wdata_o), 64'(e.wdata));
          chk("mon_req_wstrb", 64'(bus.mem_wstrb_o), 64'(e.wstrb));
        end
      end
      if (bus.ifu_resp_valid_o && bus.ifu_resp_ready_i) begin
        if (exp_ifu_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mon_ifu_unexpected: rdata 0x%0h, none expected", bus.ifu_rdata_o);
        end else begin
          d = exp_ifu_q.pop_front();
          chk("mon_ifu_rdata", 64'(bus.ifu_rdata_o), 64'(d));
        end
      end
      if (bus.lsu_resp_valid_o && bus.lsu_resp_ready_i) begin
        if (exp_lsu_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mon_lsu_unexpected: rdata 0x%0h, none expected", bus.lsu_rdata_o);
        end else begin
          d = exp_lsu_q.pop_front();
          chk("mon_lsu_rdata", 64'(bus.lsu_rdata_o), 64'(d));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int ii;
    int li;
    ii = 0;
    li = 0;

    // ---------------- reset state (requests and response present) -----------
    rst_n = 1'b0;
    bus.ifu_req_valid_i  = 1'b1;
    bus.ifu_addr_i       = 32'h8000_0000;
    bus.ifu_resp_ready_i = 1'b1;
    bus.lsu_req_valid_i  = 1'b1;
    bus.lsu_addr_i       = 32'h0;
    bus.lsu_wen_i        = 1'b0;
    bus.lsu_wdata_i      = 32'h0;
    bus.lsu_wstrb_i      = 4'h0;
    bus.lsu_resp_ready_i = 1'b1;
    bus.mem_req_ready_i  = 1'b1;
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ifu_req_ready",  64'(bus.ifu_req_ready_o),  64'd0);
    chk("rst_lsu_req_ready",  64'(bus.lsu_req_ready_o),  64'd0);
    chk("rst_mem_req_valid",  64'(bus.mem_req_valid_o),  64'd0);
    chk("rst_mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd0);
    chk("rst_ifu_resp_valid", 64'(bus.ifu_resp_valid_o), 64'd0);
    chk("rst_lsu_resp_valid", 64'(bus.lsu_resp_valid_o), 64'd0);
    chk("rst_mem_addr",       64'(bus.mem_addr_o),       64'd0);
    chk("rst_mem_wdata",      64'(bus.mem_wdata_o),      64'd0);
    @(negedge clk);
    bus.ifu_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i  = 1'b0;
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_rdata_i      = 32'h0;
    rst_n = 1'b1;

    // ---------------- lone IFU read ----------------
    @(negedge clk);
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = 32'h8000_0000;
    push_req(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    exp_ifu_q.push_back(32'h0010_0073);
    #1;
    chk("ifu_c0_ifu_ready", 64'(bus.ifu_req_ready_o), 64'd1);
    chk("ifu_c0_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd0);
    chk("ifu_c0_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
    @(negedge clk);
    bus.ifu_req_valid_i = 1'b0;
    #1;
    chk("ifu_c1_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
    chk("ifu_c1_addr",      64'(bus.mem_addr_o),      64'h8000_0000);
    chk("ifu_c1_wen",       64'(bus.mem_wen_o),       64'd0);
    chk("ifu_c1_wstrb",     64'(bus.mem_wstrb_o),     64'd0);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'h0010_0073;
    #1;
    chk("ifu_c2_resp_valid", 64'(bus.ifu_resp_valid_o), 64'd1);
    chk("ifu_c2_rdata",      64'(bus.ifu_rdata_o),      64'h0010_0073);
    chk("ifu_c2_lsu_valid",  64'(bus.lsu_resp_valid_o), 64'd0);
    chk("ifu_c2_lsu_rdata",  64'(bus.lsu_rdata_o),      64'd0);
    chk("ifu_c2_mem_ready",  64'(bus.mem_resp_ready_o), 64'd1);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;
    #1;
    chk("ifu_c3_resp_valid", 64'(bus.ifu_resp_valid_o), 64'd0);
    chk("ifu_c3_req_valid",  64'(bus.mem_req_valid_o),  64'd0);

    // ---------------- LSU write, slave stalls 3 cycles ----------------
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_addr_i      = 32'h8000_1000;
    bus.lsu_wen_i       = 1'b1;
    bus.lsu_wdata_i     = 32'hDEAD_BEEF;
    bus.lsu_wstrb_i     = 4'hF;
    push_req(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    exp_lsu_q.push_back(32'h1234_5678);
    #1;
    chk("wr_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd1);
    chk("wr_ifu_ready", 64'(bus.ifu_req_ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.lsu_req_valid_i = 1'b0;
        bus.lsu_addr_i      = 32'h0;
        bus.lsu_wen_i       = 1'b0;
        bus.lsu_wdata_i     = 32'h0;
        bus.lsu_wstrb_i     = 4'h0;
      end
      bus.mem_req_ready_i = (i == 3);
      #1;
      chk("wr_stall_valid", 64'(bus.mem_req_valid_o), 64'd1);
      chk("wr_stall_addr",  64'(bus.mem_addr_o),      64'h8000_1000);
      chk("wr_stall_wen",   64'(bus.mem_wen_o),       64'd1);
      chk("wr_stall_wdata", 64'(bus.mem_wdata_o),     64'hDEAD_BEEF);
      chk("wr_stall_wstrb", 64'(bus.mem_wstrb_o),     64'hF);
    end
    @(negedge clk);
    #1;
    chk("wr_noresp_yet", 64'(bus.lsu_resp_valid_o), 64'd0);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'h1234_5678;
    #1;
    chk("wr_lsu_resp_valid", 64'(bus.lsu_resp_valid_o), 64'd1);
    chk("wr_ifu_resp_valid", 64'(bus.ifu_resp_valid_o), 64'd0);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;

    // ---------------- simultaneous requests (fresh reset) ----------------
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bit lsu_v;
      bit lsu_win;
`ifdef ARB_ROUND_ROBIN_EN
      lsu_v   = 1'b1;
      lsu_win = (t % 2 == 0);
`else
      lsu_v   = (t < 2);
      lsu_win = (t < 2);
`endif
      @(negedge clk);
      bus.mem_resp_valid_i = 1'b0;
      bus.ifu_req_valid_i  = 1'b1;
      bus.ifu_addr_i       = 32'h8000_0100 + 32'(4 * ii);
      bus.lsu_req_valid_i  = lsu_v;
      bus.lsu_addr_i       = 32'h8000_2000 + 32'(4 * li);
      if (lsu_win) begin
        push_req(bus.lsu_addr_i, 1'b0, 32'h0, 4'h0);
        exp_lsu_q.push_back(32'hC0DE_0000 + 32'(t));
        li++;
      end else begin
        push_req(bus.ifu_addr_i, 1'b0, 32'h0, 4'h0);
        exp_ifu_q.push_back(32'hC0DE_0000 + 32'(t));
        ii++;
      end
      #1;
      chk("arb_lsu_ready", 64'(bus.lsu_req_ready_o), 64'(lsu_win));
      chk("arb_ifu_ready", 64'(bus.ifu_req_ready_o), 64'(!lsu_win));
      @(negedge clk);
      bus.ifu_addr_i = 32'h8000_0100 + 32'(4 * ii);
      bus.lsu_addr_i = 32'h8000_2000 + 32'(4 * li);
      #1;
      chk("arb_stall_ifu_ready", 64'(bus.ifu_req_ready_o), 64'd0);
      chk("arb_stall_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd0);
      chk("arb_req_valid",       64'(bus.mem_req_valid_o), 64'd1);
      @(negedge clk);
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'hC0DE_0000 + 32'(t);
      #1;
      chk("arb_ifu_resp_valid", 64'(bus.ifu_resp_valid_o), 64'(!lsu_win));
      chk("arb_lsu_resp_valid", 64'(bus.lsu_resp_valid_o), 64'(lsu_win));
    end
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;
    bus.ifu_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i  = 1'b0;

    // ---------------- response backpressure ----------------
    @(negedge clk);
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = 32'h8000_0200;
    push_req(32'h8000_0200, 1'b0, 32'h0, 4'h0);
    exp_ifu_q.push_back(32'h0BAD_F00D);
    #1;
    chk("bp_ifu_ready", 64'(bus.ifu_req_ready_o), 64'd1);
    @(negedge clk);
    bus.ifu_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i  = 1'b1;
    bus.lsu_addr_i       = 32'h8000_3000;
    bus.ifu_resp_ready_i = 1'b0;
    #1;
    chk("bp_req_valid",     64'(bus.mem_req_valid_o), 64'd1);
    chk("bp_req_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'h0BAD_F00D;
      #1;
      chk("bp_mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd0);
      chk("bp_ifu_resp_valid", 64'(bus.ifu_resp_valid_o), 64'd1);
      chk("bp_lsu_req_ready",  64'(bus.lsu_req_ready_o),  64'd0);
      chk("bp_mem_req_valid",  64'(bus.mem_req_valid_o),  64'd0);
    end
    @(negedge clk);
    bus.ifu_resp_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.mem_resp_ready_o), 64'd1);
    chk("bp_release_rdata", 64'(bus.ifu_rdata_o),      64'h0BAD_F00D);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;
    push_req(32'h8000_3000, 1'b0, 32'h0, 4'h0);
    exp_lsu_q.push_back(32'h55AA_55AA);
    #1;
    chk("bp_next_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd1);
    @(negedge clk);
    bus.lsu_req_valid_i = 1'b0;
    #1;
    chk("bp_next_addr", 64'(bus.mem_addr_o), 64'h8000_3000);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'h55AA_55AA;
    #1;
    chk("bp_next_lsu_resp", 64'(bus.lsu_resp_valid_o), 64'd1);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;

    // ---------------- reset in the middle of a request ----------------
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_addr_i      = 32'h8000_4000;
    bus.lsu_wen_i       = 1'b1;
    bus.lsu_wdata_i     = 32'hCAFE_F00D;
    bus.lsu_wstrb_i     = 4'h3;
    #1;
    chk("mid_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd1);
    @(negedge clk);
    bus.lsu_req_valid_i = 1'b0;
    bus.lsu_wen_i       = 1'b0;
    bus.lsu_wdata_i     = 32'h0;
    bus.lsu_wstrb_i     = 4'h0;
    #1;
    chk("mid_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_async_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
    chk("mid_async_addr",      64'(bus.mem_addr_o),      64'd0);
    chk("mid_async_wen",       64'(bus.mem_wen_o),       64'd0);
    chk("mid_async_wdata",     64'(bus.mem_wdata_o),     64'd0);
    chk("mid_async_wstrb",     64'(bus.mem_wstrb_o),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_req_ready_i  = 1'b1;
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_ifu_resp_valid", 64'(bus.ifu_resp_valid_o), 64'd0);
      chk("late_lsu_resp_valid", 64'(bus.lsu_resp_valid_o), 64'd0);
      chk("late_mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd0);
      chk("late_mem_req_valid",  64'(bus.mem_req_valid_o),  64'd0);
      @(negedge clk);
    end
    bus.mem_resp_valid_i = 1'b0;

    // IDLE after reset: a fresh IFU read goes straight through.
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = 32'h8000_0300;
    push_req(32'h8000_0300, 1'b0, 32'h0, 4'h0);
    exp_ifu_q.push_back(32'h0000_0013);
    #1;
    chk("post_rst_ifu_ready", 64'(bus.ifu_req_ready_o), 64'd1);
    @(negedge clk);
    bus.ifu_req_valid_i = 1'b0;
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_rdata_i      = 32'h0000_0013;
    #1;
    chk("post_rst_resp_valid", 64'(bus.ifu_resp_valid_o), 64'd1);
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;

    // ---------------- drain ----------------
    repeat (2) @(negedge clk);
    #5;
    chk("end_req_q_empty", 64'(exp_req_q.size()), 64'd0);
    chk("end_ifu_q_empty", 64'(exp_ifu_q.size()), 64'd0);
    chk("end_lsu_q_empty", 64'(exp_lsu_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester, single-port memory arbiter sitting between the instruction fetch unit (IFU), the load/store unit (LSU) and one shared memory slave port.
- Accepts one request at a time and latches it. Drives it to the slave with a valid/ready handshake, then routes the slave response back to the granted requester.
- Exactly one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, read/write data width; STRB width = DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- ifu_req_valid_i  in  1  IFU read request valid.
- ifu_req_ready_o  out  1  IFU request accepted this cycle.
- ifu_addr_i  in  ADDR_WIDTH  IFU read address.
- ifu_resp_valid_o  out  1  IFU read data valid.
- ifu_resp_ready_i  in  1  IFU can take response.
- ifu_rdata_o  out  DATA_WIDTH  IFU read data.
- lsu_req_valid_i  in  1  LSU request valid.
- lsu_req_ready_o  out  1  LSU request accepted this cycle.
- lsu_addr_i  in  ADDR_WIDTH  LSU address.
- lsu_wen_i  in  1  1 = write, 0 = read.
- lsu_wdata_i  in  DATA_WIDTH  LSU write data.
- lsu_wstrb_i  in  DATA_WIDTH/8  LSU byte strobes.
- lsu_resp_valid_o  out  1  LSU response valid; write acks included.
- lsu_resp_ready_i  in  1  LSU can take response.
- lsu_rdata_o  out  DATA_WIDTH  LSU read data.
- mem_req_valid_o  out  1  slave request valid.
- mem_req_ready_i  in  1  slave accepts request.
- mem_addr_o  out  ADDR_WIDTH  latched address.
- mem_wen_o  out  1  latched write enable.
- mem_wdata_o  out  DATA_WIDTH  latched write data.
- mem_wstrb_o  out  DATA_WIDTH/8  latched strobes.
- mem_resp_valid_i  in  1  slave response valid.
- mem_resp_ready_o  out  1  arbiter can take response.
- mem_rdata_i  in  DATA_WIDTH  slave read data.

Behaviour:
- Reset (rst_n_i low, asynchronous)
  - State forced to IDLE; owner=IFU; last_grant=IFU.
  - All latched request registers cleared; every output is 0.
  - An in-flight transaction is abandoned. Any slave response that arrives later is not forwarded.
- States: IDLE, REQ, RESP. A 1-bit owner register (IFU/LSU) is set on entry to REQ.
- IDLE
  - Winner chosen from asserted valids: fixed priority LSU > IFU (see Optional Feature).
  - Only the winner's req_ready_o is 1, combinationally, in this state; the loser's is 0.
  - On a winner handshake, latch addr/wen/wdata/wstrb. For the IFU: wen=0, wstrb=0, wdata=0.
  - Then set owner and go to REQ. With no valid request, stay in IDLE.
- REQ
  - mem_req_valid_o=1 with the latched fields, held stable until mem_req_ready_i=1, then go to RESP.
  - Minimum request latency: master handshake at cycle N gives mem_req_valid_o at N+1.
- RESP
  - mem_resp_ready_o = owner's resp_ready_i.
  - Owner's resp_valid_o = mem_resp_valid_i; owner's rdata_o = mem_rdata_i (combinational pass-through). The non-owner's resp_valid_o is 0 and its rdata_o is 0.
  - On mem_resp_valid_i && mem_resp_ready_o: update last_grant=owner, go to IDLE.
  - The next master request can be accepted one cycle after the response handshake.
- mem_resp_valid_i in IDLE or REQ is illegal: it is ignored and mem_resp_ready_o=0.
- Both req_ready_o are 0 outside IDLE. A master holding valid across REQ/RESP is simply stalled.
- A write gets a response (lsu_resp_valid_o) whose rdata is don't-care to the LSU. The arbiter still forwards mem_rdata_i.
- Backpressure: resp_ready_i low holds RESP indefinitely; no data loss.

Optional Feature:
- ARB_ROUND_ROBIN_EN
  - Defined: on a simultaneous IFU+LSU request in IDLE, the grant goes to the requester that is NOT last_grant. A lone requester always wins.
  - Undefined: fixed priority LSU > IFU; last_grant is still maintained but unused.

Test Plan:
- Lone IFU read:
  - Stimulus: ifu addr=0x80000000, slave ready immediately, rdata=0x00100073 two cycles later.
  - Required: ifu_req_ready_o=1 at cycle 0; mem_req_valid_o=1 with addr 0x80000000, wen=0, wstrb=0 at cycle 1; ifu_resp_valid_o with rdata 0x00100073; lsu_resp_valid_o stays 0.
- LSU write with stalled slave:
  - Stimulus: addr=0x80001000, wdata=0xDEADBEEF, wstrb=0xF, mem_req_ready_i low 3 cycles.
  - Required: mem_* fields stable for all 4 cycles of mem_req_valid_o; lsu_resp_valid_o after the slave response.
- Simultaneous requests, macro undefined:
  - Stimulus: both valids high for 2 back-to-back transactions.
  - Required: LSU granted both times; IFU granted only after LSU drops valid.
- Simultaneous requests, ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both held valid for 4 transactions.
  - Required: grants alternate LSU, IFU, LSU, IFU (first is LSU since last_grant resets to IFU).
- Response backpressure:
  - Stimulus: ifu_resp_ready_i low 5 cycles with mem_resp_valid_i high.
  - Required: mem_resp_ready_o=0 for those cycles; state stays RESP; no new grant; single handshake when ready rises.
- Reset mid-transaction:
  - Stimulus: rst_n_i low asynchronously while in REQ.
  - Required: mem_req_valid_o drops to 0 without a clock edge; after release, state is IDLE and a late mem_resp_valid_i produces no resp_valid_o.
